keypad_debounce: RTL and testbench

//   Front-end stage directly upstream of the password door lock controller.

---
 rtl/keypad_pkg.sv | 27 ++
 rtl/key_debounce_cell.sv | 54 +++++
 rtl/keypad_debounce.sv | 128 ++++++++++++
 tb/tb_keypad_debounce.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad debounce front-end:
// key width, FSM state encoding and one-hot decode helpers.
package keypad_pkg;

    localparam int unsigned KEY_W  = 4;
    localparam int unsigned CODE_W = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } kp_state_e;

    function automatic logic is_onehot(input logic [KEY_W-1:0] v);
        return (v != {KEY_W{1'b0}}) && ((v & (v - KEY_W'(1))) == {KEY_W{1'b0}});
    endfunction

    // Only meaningful for a one-hot argument; bits are OR-ed so no priority logic is built.
    function automatic logic [CODE_W-1:0] onehot_to_index(input logic [KEY_W-1:0] oh);
        logic [CODE_W-1:0] idx;
        idx = {CODE_W{1'b0}};
        for (int i = 0; i < int'(KEY_W); i++) begin
            idx = idx | (oh[i] ? CODE_W'(i) : {CODE_W{1'b0}});
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One push-button lane: two-flop synchroniser followed by a saturating
// stability counter that commits a new debounced level after a full quiet run.
module key_debounce_cell #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic db_out
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: any sample agreeing with the committed level restarts the run.
    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = CNT_ZERO;
        if (sync2_q == db_q) begin
            cnt_d = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
            db_d  = sync2_q;
            cnt_d = CNT_ZERO;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Lane state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= CNT_ZERO;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db_out = db_q;

endmodule

// File: rtl/keypad_debounce.sv
// Keypad front-end: debounces four buttons and emits at most one clean
// one-hot key event per press, flagging ambiguous simultaneous presses.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [KEY_W-1:0]  raw_key,
    input  logic              en,
    output logic [KEY_W-1:0]  key,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              multi_err,
    output logic              busy
);

    logic [KEY_W-1:0]  db_s;
    logic              db_any_s;

    kp_state_e         state_q, state_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [CODE_W-1:0] key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic              multi_err_q, multi_err_d;
    logic              busy_q, busy_d;

    for (genvar g = 0; g < int'(KEY_W); g++) begin : g_cell
        key_debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_cell (
            .clk    (clk),
            .reset  (reset),
            .raw_in (raw_key[g]),
            .db_out (db_s[g])
        );
    end

    assign db_any_s = (db_s != {KEY_W{1'b0}});

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: HELD lasts until every debounced key is released.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (db_any_s) begin
                    state_d = ST_HELD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HELD: begin
                if (db_any_s) begin
                    state_d = ST_HELD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: events only on the IDLE->HELD transition and only when enabled.
    always_comb begin
        key_d       = {KEY_W{1'b0}};
        key_code_d  = {CODE_W{1'b0}};
        key_valid_d = 1'b0;
        multi_err_d = 1'b0;
        busy_d      = db_any_s;
        case (state_q)
            ST_IDLE: begin
                if (db_any_s && en) begin
                    if (is_onehot(db_s)) begin
                        key_d       = db_s;
                        key_code_d  = onehot_to_index(db_s);
                        key_valid_d = 1'b1;
                    end else begin
                        multi_err_d = 1'b1;
                    end
                end else begin
                    key_valid_d = 1'b0;
                end
            end
            ST_HELD: begin
                key_valid_d = 1'b0;
            end
            default: begin
                key_valid_d = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_q       <= {KEY_W{1'b0}};
            key_code_q  <= {CODE_W{1'b0}};
            key_valid_q <= 1'b0;
            multi_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            key_q       <= key_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            multi_err_q <= multi_err_d;
            busy_q      <= busy_d;
        end
    end

    assign key       = key_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign multi_err = multi_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_keypad_debounce.sv
// Bench for keypad_debounce: directed press scenarios plus random stimulus,
// every cycle compared against a sliding-window reference model.
module tb_keypad_debounce;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] raw_key;
    logic [3:0] key;
    logic [1:0] key_code;
    logic       key_valid;
    logic       multi_err;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    keypad_debounce #(
        .DEBOUNCE_CYCLES (N),
        .CNT_W           (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .raw_key   (raw_key),
        .en        (en),
        .key       (key),
        .key_code  (key_code),
        .key_valid (key_valid),
        .multi_err (multi_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: sync = raw delayed two edges; a level is accepted when
    // the last N synchronised samples all disagree with the current level.
    int         cyc = 0;
    bit         m_valid = 1'b0;
    logic [3:0] h1 = 4'd0, h2 = 4'd0, m_db = 4'd0;
    logic       m_any_prev = 1'b0;
    logic [N-1:0] win [4];
    logic [3:0] e_key = 4'd0;
    logic [1:0] e_code = 2'd0;
    logic       e_valid = 1'b0, e_multi = 1'b0, e_busy = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_valid = 1'b1;
            h1 = 4'd0; h2 = 4'd0; m_db = 4'd0; m_any_prev = 1'b0;
            for (int i = 0; i < 4; i++) win[i] = '0;
            e_key = 4'd0; e_code = 2'd0; e_valid = 1'b0; e_multi = 1'b0; e_busy = 1'b0;
        end else if (m_valid) begin
            e_key = 4'd0; e_code = 2'd0; e_valid = 1'b0; e_multi = 1'b0;
            e_busy = (m_db != 4'd0);
            if (m_db != 4'd0 && !m_any_prev && en) begin
                if ($countones(m_db) == 1) begin
                    e_key = m_db;
                    e_valid = 1'b1;
                    for (int i = 0; i < 4; i++) if (m_db[i]) e_code = 2'(i);
                end else begin
                    e_multi = 1'b1;
                end
            end
            m_any_prev = (m_db != 4'd0);
            for (int i = 0; i < 4; i++) begin
                win[i] = {win[i][N-2:0], h2[i]};
                if (win[i] == {N{~m_db[i]}}) m_db[i] = ~m_db[i];
            end
            h2 = h1;
            h1 = raw_key;
        end
    end

    int         pulse_cnt = 0, multi_cnt = 0, pulse_edge = 0, busy_rise = 0;
    logic [3:0] last_key = 4'd0;
    bit         busy_prev = 1'b0;

    always @(negedge clk) begin
        if (m_valid) begin
            check_eq("key", {28'd0, key}, {28'd0, e_key});
            check_eq("key_code", {30'd0, key_code}, {30'd0, e_code});
            check_eq("key_valid", {31'd0, key_valid}, {31'd0, e_valid});
            check_eq("multi_err", {31'd0, multi_err}, {31'd0, e_multi});
            check_eq("busy", {31'd0, busy}, {31'd0, e_busy});
        end
        if (key_valid === 1'b1) begin
            pulse_cnt++;
            pulse_edge = cyc;
            last_key = key;
        end
        if (multi_err === 1'b1) multi_cnt++;
        if (busy === 1'b1 && !busy_prev) busy_rise = cyc;
        busy_prev = (busy === 1'b1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    int base, base_m, t0, sel;

    initial begin
        reset = 1'b1; en = 1'b1; raw_key = 4'd0;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(2);

        // Clean press of key 2
        base = pulse_cnt; raw_key = 4'b0010; t0 = cyc;
        wait_cyc(20);
        check_eq("clean_pulses", pulse_cnt - base, 32'd1);
        check_eq("clean_latency", pulse_edge - t0, 32'd7);
        check_eq("clean_key", {28'd0, last_key}, 32'h2);
        check_eq("busy_rise", busy_rise - t0, 32'd7);
        raw_key = 4'd0; wait_cyc(10);

        // Bounce on key 1 then steady press
        base = pulse_cnt;
        for (int k = 0; k < 12; k++) begin
            raw_key = (((k / 2) % 2) == 0) ? 4'b0001 : 4'b0000;
            wait_cyc(1);
        end
        raw_key = 4'b0001; t0 = cyc;
        wait_cyc(20);
        check_eq("bounce_pulses", pulse_cnt - base, 32'd1);
        check_eq("bounce_latency", pulse_edge - t0, 32'd7);
        raw_key = 4'd0; wait_cyc(10);

        // Long hold, no auto-repeat; then a different key
        base = pulse_cnt; raw_key = 4'b0100; wait_cyc(200);
        raw_key = 4'd0; wait_cyc(10);
        raw_key = 4'b1000; wait_cyc(20);
        check_eq("hold_pulses", pulse_cnt - base, 32'd2);
        check_eq("second_key", {28'd0, last_key}, 32'h8);
        raw_key = 4'd0; wait_cyc(10);

        // Short release gap is absorbed as bounce
        base = pulse_cnt; raw_key = 4'b0001; wait_cyc(20);
        raw_key = 4'd0; wait_cyc(2);
        raw_key = 4'b0001; wait_cyc(20);
        check_eq("short_gap_pulses", pulse_cnt - base, 32'd1);
        raw_key = 4'd0; wait_cyc(10);

        // Simultaneous press, then add/remove while held
        base = pulse_cnt; base_m = multi_cnt;
        raw_key = 4'b0101; wait_cyc(20);
        raw_key = 4'b0111; wait_cyc(10);
        raw_key = 4'b0001; wait_cyc(10);
        raw_key = 4'd0; wait_cyc(10);
        check_eq("multi_count", multi_cnt - base_m, 32'd1);
        check_eq("multi_no_pulse", pulse_cnt - base, 32'd0);

        // Reset mid-debounce discards the partial count
        base = pulse_cnt; raw_key = 4'b0010; wait_cyc(4);
        reset = 1'b1; raw_key = 4'd0; wait_cyc(1);
        reset = 1'b0; wait_cyc(10);
        check_eq("reset_no_pulse", pulse_cnt - base, 32'd0);
        raw_key = 4'b0010; t0 = cyc; wait_cyc(20);
        check_eq("post_reset_pulses", pulse_cnt - base, 32'd1);
        check_eq("post_reset_latency", pulse_edge - t0, 32'd7);
        raw_key = 4'd0; wait_cyc(10);

        // Enable gating
        base = pulse_cnt; en = 1'b0; raw_key = 4'b0010; wait_cyc(20);
        en = 1'b1; wait_cyc(10);
        check_eq("en_low_no_pulse", pulse_cnt - base, 32'd0);
        raw_key = 4'd0; wait_cyc(10);
        raw_key = 4'b0010; wait_cyc(20);
        check_eq("en_high_pulse", pulse_cnt - base, 32'd1);
        raw_key = 4'd0; wait_cyc(10);

        // Random stimulus with hold times straddling the debounce threshold
        repeat (400) begin
            sel = $urandom_range(0, 9);
            if (sel < 4) raw_key = 4'(1 << sel);
            else if (sel < 7) raw_key = 4'd0;
            else raw_key = 4'($urandom_range(0, 15));
            en = ($urandom_range(0, 4) != 0);
            reset = ($urandom_range(0, 59) == 0);
            wait_cyc(1);
            reset = 1'b0;
            wait_cyc($urandom_range(0, 8));
        end
        raw_key = 4'd0; en = 1'b1;
        wait_cyc(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
